// File: rtl/ahb_console_uart.sv
// ahb_console_uart: AHB-Lite slave that queues bytes in a TX FIFO and sends them as 8N1 UART frames.
// Ports: i_hclk/i_hreset_n clock and async active-low reset; i_hsel, i_haddr, i_htrans, i_hwrite,
// i_hsize, i_hwdata, i_hready AHB slave inputs; o_hrdata, o_hready, o_hresp AHB slave outputs;
// o_txd registered serial line (idle high). Registers at addr[3:2]: 0 DATA, 1 STATUS, 2 DIV.
module ahb_console_uart #(
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        i_hclk,
    input  logic        i_hreset_n,
    input  logic        i_hsel,
    input  logic [31:0] i_haddr,
    input  logic [1:0]  i_htrans,
    input  logic        i_hwrite,
    input  logic [2:0]  i_hsize,
    input  logic [31:0] i_hwdata,
    input  logic        i_hready,
    output logic [31:0] o_hrdata,
    output logic        o_hready,
    output logic [1:0]  o_hresp,
    output logic        o_txd
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          valid_q, write_q;
    logic [1:0]    addr_q;
    logic [15:0]   div_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    state_t        state_q, state_d;
    logic [15:0]   bcnt_q, bcnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          txd_q;
    logic          full, empty, data_wr, div_wr, push, pop;
    logic [31:0]   status;
    logic          unused_ok;

    assign unused_ok = ^{i_hsize, i_haddr[31:4], i_haddr[1:0], i_hwdata[31:16]};

    assign full    = cnt_q == (AW+1)'(FIFO_DEPTH);
    assign empty   = cnt_q == '0;
    assign data_wr = valid_q && write_q && addr_q == 2'd0;
    assign div_wr  = valid_q && write_q && addr_q == 2'd2 && i_hready;
    // A DATA write stalls while full; the byte is taken in the cycle the stall ends.
    assign o_hready = !(data_wr && full);
    assign push     = data_wr && !full && i_hready;
    assign o_hresp  = 2'b00;
    assign o_txd    = txd_q;

    assign status   = (32'(cnt_q) << 8) | {29'd0, state_q != IDLE, empty, full};
    assign o_hrdata = (!valid_q || write_q) ? 32'd0 :
                      (addr_q == 2'd1)      ? status :
                      (addr_q == 2'd2)      ? {16'd0, div_q} : 32'd0;

    always_ff @(posedge i_hclk) begin
        if (push) mem_q[wp_q] <= i_hwdata[7:0];
    end

    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            valid_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= 2'd0;
            div_q   <= DEFAULT_DIV;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            bcnt_q  <= 16'd0;
            bit_q   <= 3'd0;
            sh_q    <= 8'd0;
            txd_q   <= 1'b1;
        end else begin
            if (i_hready) begin
                valid_q <= i_hsel && i_htrans[1];
                write_q <= i_hwrite;
                addr_q  <= i_haddr[3:2];
            end
            if (div_wr) div_q <= (i_hwdata[15:0] == 16'd0) ? 16'd1 : i_hwdata[15:0];
            wp_q    <= wp_q + AW'(push);
            rp_q    <= rp_q + AW'(pop);
            cnt_q   <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            // Line level follows the current state, so it lags the state change by one clock.
            txd_q   <= (state_q == START) ? 1'b0 : (state_q == DATA) ? sh_q[0] : 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        pop     = 1'b0;
        if (state_q == IDLE) begin
            if (!empty) begin
                pop     = 1'b1;
                sh_d    = mem_q[rp_q];
                bcnt_d  = div_q;
                state_d = START;
            end
        end else if (bcnt_q != 16'd1) begin
            bcnt_d = bcnt_q - 16'd1;
        end else begin
            // Bit period ends: reload from DIV so a new divisor takes effect at the next bit.
            bcnt_d = div_q;
            case (state_q)
                START: begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
                DATA: begin
                    sh_d    = sh_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    state_d = (bit_q == 3'd7) ? STOP : DATA;
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_console_uart.sv
// tb_ahb_console_uart: directed self-checking bench for the AHB console UART.
module tb_ahb_console_uart;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = 32'd0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b010;
    logic [31:0] hwdata = 32'd0;
    logic        tb_rdy = 1'b1;
    logic        bus_rdy;
    logic [31:0] hrdata;
    logic        hready;
    logic [1:0]  hresp;
    logic        txd;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int mon_en = 0;
    int mon_div = 4;
    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic [7:0] bd[32];
    int         bw[32];

    assign bus_rdy = hready & tb_rdy;

    ahb_console_uart dut (
        .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(hsel), .i_haddr(haddr),
        .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hwdata(hwdata),
        .i_hready(bus_rdy), .o_hrdata(hrdata), .o_hready(hready), .o_hresp(hresp),
        .o_txd(txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        int w = 0;
        @(negedge clk); hsel = 1; htrans = 2'b10; hwrite = 1; haddr = a;
        @(posedge clk);
        @(negedge clk); hsel = 0; htrans = 2'b00; hwdata = d;
        while (!hready && w < 200) begin @(negedge clk); w++; end
        if (w == 200) check("wr_timeout", w, 0);
        @(posedge clk);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk); hsel = 1; htrans = 2'b10; hwrite = 0; haddr = a;
        @(posedge clk);
        @(negedge clk); hsel = 0; htrans = 2'b00;
        #1 d = hrdata;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    task automatic raw(input logic sel, input logic [1:0] tr, input logic rdy,
                       input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); hsel = sel; htrans = tr; hwrite = 1; haddr = a; tb_rdy = rdy;
        @(posedge clk);
        @(negedge clk); hsel = 0; htrans = 2'b00; tb_rdy = 1; hwdata = d;
        @(posedge clk);
    endtask

    // Pipelined DATA writes: address phase of beat i overlaps the data phase of beat i-1.
    task automatic burst(input int n);
        int w;
        @(negedge clk);
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin hsel = 1; htrans = 2'b10; hwrite = 1; haddr = 32'd0; end
            else begin hsel = 0; htrans = 2'b00; end
            if (i > 0) hwdata = {24'd0, bd[i-1]};
            w = 0;
            while (!hready && w < 200) begin @(negedge clk); w++; end
            if (w == 200) check("burst_timeout", w, 0);
            if (i > 0) bw[i-1] = w;
            @(negedge clk);
        end
    endtask

    task automatic wait_rx(input int n);
        int t = 0;
        while (rx_q.size() < n && t < 3000) begin @(negedge clk); t++; end
        check("rx_count", rx_q.size(), n);
    endtask

    // Frame monitor: samples mid-bit from the first low level, records byte and start cycle.
    initial begin
        logic [7:0] b;
        int t;
        forever begin
            @(negedge clk);
            if (mon_en != 0 && rst_n && txd == 1'b0) begin
                t = cyc;
                repeat (mon_div + mon_div / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    b[i] = txd;
                    if (i < 7) repeat (mon_div) @(negedge clk);
                end
                repeat (mon_div) @(negedge clk);
                check("stop_bit", txd, 1);
                rx_q.push_back(b);
                rx_t.push_back(t);
            end
        end
    end

    initial begin
        logic [9:0] frame;
        int sum, lows;
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_hready", hready, 1);
        check("rst_hrdata", hrdata, 0);
        check("rst_hresp", hresp, 0);
        rst_n = 1;

        rd_chk("div_reset", 32'h8, 32'h0000_0364);
        rd_chk("status_reset", 32'h4, 32'h0000_0002);
        wr(32'h8, 32'h0);
        rd_chk("div_zero", 32'h8, 32'h0000_0001);

        raw(1'b0, 2'b10, 1'b1, 32'h8, 32'h7);
        raw(1'b1, 2'b00, 1'b1, 32'h0, 32'h55);
        raw(1'b1, 2'b10, 1'b0, 32'h8, 32'h9);
        raw(1'b1, 2'b10, 1'b0, 32'h0, 32'h66);
        wr(32'hC, 32'hC);
        rd_chk("status_noxfer", 32'h4, 32'h0000_0002);
        rd_chk("div_noxfer", 32'h8, 32'h0000_0001);
        rd_chk("rsvd_read", 32'hC, 32'h0);
        rd_chk("data_read", 32'h0, 32'h0);
        check("txd_noxfer", txd, 1);

        wr(32'h8, 32'h4);
        wr(32'h0, 32'hFFFF_FF41);
        frame = {1'b1, 8'h41, 1'b0};
        for (int k = 1; k <= 46; k++) begin
            @(negedge clk);
            check($sformatf("txd_k%0d", k), txd,
                  (k < 3 || k > 42) ? 1 : frame[(k - 3) / 4]);
        end
        rd_chk("status_after_frame", 32'h4, 32'h0000_0002);

        mon_div = 4; mon_en = 1;
        bd[0] = 8'h11; bd[1] = 8'h22; bd[2] = 8'h33; bd[3] = 8'h44;
        burst(4);
        rd_chk("status_3q_busy", 32'h4, 32'h0000_0304);
        wait_rx(4);
        for (int i = 0; i < 4; i++) check($sformatf("rx4_%0d", i), rx_q[i], bd[i]);
        repeat (10) @(negedge clk);
        rx_q.delete(); rx_t.delete();

        wr(32'h8, 32'h2);
        mon_div = 2;
        wr(32'h0, 32'hA0);
        for (int i = 0; i < 17; i++) bd[i] = 8'h01 + 8'(i * 11);
        burst(17);
        sum = 0;
        for (int i = 0; i < 16; i++) sum += bw[i];
        check("burst_nowait", sum, 0);
        check("burst_17th_wait", bw[16], 5);
        wait_rx(18);
        check("rx18_lead", rx_q[0], 8'hA0);
        for (int i = 0; i < 17; i++) check($sformatf("rx18_%0d", i), rx_q[i+1], bd[i]);
        for (int i = 1; i < 18; i++) check($sformatf("pitch_%0d", i), rx_t[i] - rx_t[i-1], 21);
        repeat (10) @(negedge clk);
        mon_en = 0;

        wr(32'h8, 32'h4);
        wr(32'h0, 32'h00);
        repeat (12) @(negedge clk);
        check("pre_rst_txd", txd, 0);
        #1 rst_n = 0;
        #1;
        check("midrst_txd", txd, 1);
        check("midrst_hready", hready, 1);
        check("midrst_hrdata", hrdata, 0);
        repeat (3) @(negedge clk);
        rst_n = 1; hsel = 1; htrans = 2'b10; hwrite = 1; haddr = 32'h8;
        @(posedge clk);
        @(negedge clk); hsel = 0; htrans = 2'b00; hwdata = 32'h3;
        @(posedge clk);
        rd_chk("div_first_edge", 32'h8, 32'h0000_0003);
        rd_chk("status_after_rst", 32'h4, 32'h0000_0002);
        lows = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (txd == 1'b0) lows++;
        end
        check("no_frame_after_rst", lows, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
